tnn_stream_classifier: RTL and testbench
========================================

Name: tnn_stream_classifier

Overview:
- Sequential, parametrised successor to the fixed 6×3-bit single-output combinational TNN classifier cores.
- Accepts one feature vector as a serial stream of unsigned FEAT_W-bit features over a valid/ready handshake.
- Evaluates N_NEUR ternary-weight neurons in parallel and emits an N_NEUR-bit class vector.
- Sits between the feature quantiser and the downstream voting/decision logic.
- Adds what the fixed core lacks: runtime streaming, back-pressure, framing check, and a configurable feature/neuron count.

Parameters:
- N_FEAT, 6, features per frame (≥2).
- FEAT_W, 3, feature width, unsigned.
- N_NEUR, 2, number of neurons / output bits.
- ACC_W, 7, signed accumulator width. Must be ≥ clog2(N_FEAT·(2^FEAT_W−1)+1)+1. No saturation.
- W_POS, 12'b111111_000011, N_NEUR·N_FEAT bits. Bit [n·N_FEAT+i] gives neuron n weight +1 on feature i.
- W_NEG, 12'b000000_001100, same layout. Gives weight −1. If a bit is set in both W_POS and W_NEG, the weight is 0.
- THRESH, {7'sd20,7'sd0}, N_NEUR·ACC_W bits. Signed threshold per neuron; slice n is [n·ACC_W +: ACC_W].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  feature beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  FEAT_W  feature value, unsigned
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  class vector valid
- out_ready  in  1  downstream accepts the class vector
- out_class  out  N_NEUR  bit n = (acc_n ≥ THRESH_n)
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset values: idx=0, all acc_n=0, out_valid=0, out_class=0, frame_err=0. in_ready is 1 after reset.
- A beat is accepted when in_valid && in_ready.
- On each accepted beat, for every neuron n: contrib = +in_data, −in_data or 0 according to the weight on feature idx. in_data is zero-extended to ACC_W before the signed add.
- Non-final accepted beat (idx < N_FEAT−1):
  - in_last=0: acc_n ← acc_n + contrib; idx ← idx+1.
  - in_last=1: early termination. Pulse frame_err for one cycle, set all acc_n←0 and idx←0, produce no output.
- Final accepted beat (idx = N_FEAT−1):
  - out_class[n] ← (acc_n + contrib ≥ THRESH_n), signed compare on the combinational next value.
  - out_valid ← 1; acc_n ← 0; idx ← 0.
  - If in_last=0 on this beat, pulse frame_err, but the output is still produced.
- Latency: out_valid rises on the clock edge that accepts the final beat, i.e. it is visible the cycle after that beat.
- Output handshake:
  - out_valid && out_ready clears out_valid on the next edge.
  - out_class holds its value while out_valid is high.
  - out_class also holds its value after the output handshake, until the next frame completes.
- Pipelining: the next frame's beats are accepted while an output is pending.
- in_ready = !(idx = N_FEAT−1 && out_valid && !out_ready).
  - Only the final beat stalls on a pending output.
  - If out_ready and the final beat coincide, the old output is consumed and the new one is loaded on the same edge, so out_valid stays 1.
- Wrap-around: idx runs 0..N_FEAT−1 and wraps to 0 after the final beat.
- Asynchronous reset mid-frame or mid-output discards all state immediately. No output is produced for the partial frame.
- in_data and in_last are ignored when in_valid=0.

Test Plan:
1. Defaults. Frame 7,7,1,1,0,0, in_last on beat 5, out_ready=1.
   -> out_valid one cycle after beat 5. n0 acc=14−2=12 ≥ 0, n1 acc=16 < 20, so out_class=2'b01. frame_err=0.
2. Frame 0,0,7,7,7,7.
   -> n0 acc=−14 < 0, n1 acc=28 ≥ 20, so out_class=2'b10. Confirms signed compare.
3. out_ready=0. Send frame A (test 1), then frame B (test 2) back-to-back.
   -> B beats 0–4 accepted. in_ready=0 at B beat 5. out_class stays 2'b01.
   -> Raise out_ready. B beat 5 accepted on that edge, out_valid stays 1, out_class becomes 2'b10.
4. in_last=1 on beat 2.
   -> frame_err pulses for exactly 1 cycle, no out_valid. Next full frame 7,7,1,1,0,0 gives 2'b01, proving the accumulators were cleared.
5. Build with W_POS=W_NEG=12'hFFF, THRESH={0,0}. Frame 7,7,7,7,7,7.
   -> every weight is 0, so acc=0 and out_class=2'b11.
6. Assert rst_n=0 asynchronously after beat 3, release, then send test-2 frame.
   -> out_valid=0 and in_ready=1 during reset. After release the frame yields 2'b10 with no residue from the aborted frame.

Source files
------------

// File: rtl/tnn_stream_classifier.sv
// tnn_stream_classifier: streams FEAT_W-bit features over valid/ready and
// evaluates N_NEUR ternary-weight neurons, emitting one class vector per frame.
module tnn_stream_classifier #(
  parameter int N_FEAT = 6,
  parameter int FEAT_W = 3,
  parameter int N_NEUR = 2,
  parameter int ACC_W = 7,
  parameter logic [N_NEUR*N_FEAT-1:0] W_POS = 12'b111111_000011,
  parameter logic [N_NEUR*N_FEAT-1:0] W_NEG = 12'b000000_001100,
  parameter logic [N_NEUR*ACC_W-1:0] THRESH = {7'sd20, 7'sd0}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_NEUR-1:0] out_class,
  output logic              frame_err
);
  localparam int IDX_W = $clog2(N_FEAT);
  logic [IDX_W-1:0] idx;
  logic signed [ACC_W-1:0] acc [N_NEUR];
  logic signed [ACC_W-1:0] acc_nxt [N_NEUR];
  logic [N_NEUR-1:0] cls;
  logic last_idx, accept, restart;
  assign last_idx = idx == IDX_W'(N_FEAT - 1);
  // only the final beat has to wait for a pending class vector to drain
  assign in_ready = !(last_idx && out_valid && !out_ready);
  assign accept = in_valid && in_ready;
  assign restart = last_idx || in_last;
  genvar g;
  for (g = 0; g < N_NEUR; g++) begin : g_neur
    localparam logic [N_FEAT-1:0] WP = W_POS[g*N_FEAT +: N_FEAT];
    localparam logic [N_FEAT-1:0] WN = W_NEG[g*N_FEAT +: N_FEAT];
    localparam logic signed [ACC_W-1:0] TH = THRESH[g*ACC_W +: ACC_W];
    logic signed [ACC_W-1:0] d;
    assign d = $signed(ACC_W'(in_data));
    assign acc_nxt[g] = (WP[idx] && !WN[idx]) ? acc[g] + d :
                        (WN[idx] && !WP[idx]) ? acc[g] - d : acc[g];
    assign cls[g] = acc_nxt[g] >= TH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int n = 0; n < N_NEUR; n++) acc[n] <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= (accept && last_idx) || (out_valid && !out_ready);
      // in_last must coincide exactly with the final beat
      frame_err <= accept && (last_idx != in_last);
      if (accept) begin
        idx <= restart ? '0 : idx + 1'b1;
        for (int n = 0; n < N_NEUR; n++) acc[n] <= restart ? '0 : acc_nxt[n];
        if (last_idx) out_class <= cls;
      end
    end
  end
endmodule

// File: tb/tb_tnn_stream_classifier.sv
// tb_tnn_stream_classifier: directed and randomized frames checked against an
// arithmetic dot-product model, with a second all-zero-weight instance.
module tb_tnn_stream_classifier;
  localparam logic [11:0] WP = 12'b111111_000011;
  localparam logic [11:0] WN = 12'b000000_001100;
  localparam logic [13:0] TH = {7'sd20, 7'sd0};
  localparam logic [17:0] FA = {3'd0, 3'd0, 3'd1, 3'd1, 3'd7, 3'd7};
  localparam logic [17:0] FB = {3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [2:0] in_data = '0;
  logic in_ready, out_valid, frame_err, in_ready2, out_valid2, frame_err2;
  logic [1:0] out_class, out_class2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  tnn_stream_classifier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .frame_err(frame_err));
  tnn_stream_classifier #(.W_POS(12'hFFF), .W_NEG(12'hFFF), .THRESH(14'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_class(out_class2), .frame_err(frame_err2));
  function automatic logic [1:0] model(input logic [17:0] fv, input logic [11:0] wp, wn,
                                       input logic [13:0] th);
    logic [1:0] r;
    for (int n = 0; n < 2; n++) begin
      int s = 0;
      for (int i = 0; i < 6; i++) begin
        int f = int'(fv[3*i +: 3]);
        if (wp[n*6+i] && !wn[n*6+i]) s += f;
        else if (wn[n*6+i] && !wp[n*6+i]) s -= f;
      end
      r[n] = s >= int'($signed(th[n*7 +: 7]));
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [2:0] d, input logic last);
    int n = 0;
    in_valid = 1; in_data = d; in_last = last;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    if (n == 64) chk("beat_timeout", 32'(n), 32'd0);
    @(posedge clk); @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run_frame(input logic [17:0] fv, input bit tag_last, input string tag);
    for (int i = 0; i < 6; i++) beat(fv[3*i +: 3], i == 5 && tag_last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_class"}, 32'(out_class), 32'(model(fv, WP, WN, TH)));
    chk({tag, "_err"}, 32'(frame_err), 32'(!tag_last));
    chk({tag, "_class0w"}, 32'({out_valid2, out_class2}), 32'b111);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_class", 32'(out_class), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);
    run_frame(FA, 1, "t1");
    chk("t1_class_val", 32'(out_class), 32'b01);
    @(negedge clk);
    chk("t1_consumed", 32'(out_valid), 32'd0);
    run_frame(FB, 1, "t2");
    chk("t2_class_val", 32'(out_class), 32'b10);
    @(negedge clk);
    out_ready = 0;
    run_frame(FA, 1, "t3a");
    for (int i = 0; i < 5; i++) beat(FB[3*i +: 3], 0);
    in_valid = 1; in_data = FB[17:15]; in_last = 1;
    #1 chk("t3_stall", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t3_stall2", 32'(in_ready), 32'd0);
    chk("t3_hold", 32'({out_valid, out_class}), 32'b101);
    out_ready = 1;
    #1 chk("t3_release", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("t3_swap", 32'({out_valid, out_class}), 32'b110);
    @(negedge clk);
    chk("t3_drain", 32'({out_valid, out_class}), 32'b010);
    beat(7, 0); beat(7, 0); beat(1, 1);
    chk("t4_err", 32'({frame_err, out_valid}), 32'b10);
    @(negedge clk);
    chk("t4_err_off", 32'({frame_err, out_valid}), 32'b00);
    run_frame(FA, 1, "t4");
    @(negedge clk);
    run_frame(FB, 0, "t4nolast");
    @(negedge clk);
    run_frame({6{3'd7}}, 1, "t5");
    @(negedge clk);
    out_ready = 0;
    run_frame(FB, 1, "t6pre");
    for (int i = 0; i < 4; i++) beat(FA[3*i +: 3], 0);
    #2 rst_n = 0;
    #1 chk("t6_rst", 32'({out_valid, in_ready, out_class, frame_err}), 32'b01000);
    chk("t6_rst0w", 32'({out_valid2, out_class2}), 32'b000);
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("t6_idle", 32'(out_valid), 32'd0);
    run_frame(FB, 1, "t6");
    @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      logic [17:0] fv = 18'($urandom);
      logic [1:0] ec = model(fv, WP, WN, TH);
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(fv, $urandom_range(0, 3) != 0, "rnd");
      if (!out_ready) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk("rnd_pending", 32'({out_valid, out_class}), 32'({1'b1, ec}));
        out_ready = 1;
      end
      @(negedge clk);
      chk("rnd_after", 32'({out_valid, out_class}), 32'({1'b0, ec}));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
